// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: fetch-time prediction record and FSM states.
// Record width follows BRU_XLEN; the top-level XLEN parameter must match it.
package bru_pkg;

   localparam int BRU_XLEN    = 32;
   localparam int INSTR_BYTES = 4;

   typedef struct packed {
      logic [BRU_XLEN-1:0] pc;
      logic                pred_taken;
      logic [BRU_XLEN-1:0] pred_target;
   } pred_rec_t;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } bru_state_e;

endpackage

// File: rtl/branch_resolve_unit_pred_fifo.sv
// Circular buffer of prediction records; head is readable combinationally, and push,
// pop and clear take effect at the clock edge. Clear overrides any push or pop.
module pred_fifo
   import bru_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     clear_i,
   input  pred_rec_t                wdat_i,
   output pred_rec_t                rdat_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   pred_rec_t       mem_q [DEPTH];
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Pointers are power-of-two wide, so plain increments wrap modulo DEPTH.
         if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdat_i;
   end

   assign rdat_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/branch_resolve_unit.sv
// EXE branch resolution: compares resolved branches with queued fetch predictions, updates
// the predictor same-cycle, flushes/redirects one cycle after a mispredict. Optional BRU_PERF_CNT_EN.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int PRED_DEPTH = 4,
   parameter int XLEN       = BRU_XLEN
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            if_push,
   input  logic [XLEN-1:0] if_pc,
   input  logic            if_pred_taken,
   input  logic [XLEN-1:0] if_pred_target,
   output logic            q_full,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            ex_taken,
   input  logic [XLEN-1:0] ex_target,
   output logic            bp_update,
   output logic            bp_actual_taken,
   output logic            flush,
   output logic [XLEN-1:0] redirect_pc,
`ifdef BRU_PERF_CNT_EN
   output logic [31:0]     perf_branches,
   output logic [31:0]     perf_mispredicts,
`endif
   output logic            desync
);

   localparam int CW = $clog2(PRED_DEPTH) + 1;

   bru_state_e      state_q, state_d;
   logic [XLEN-1:0] redirect_q, redirect_d;
   logic            desync_q, desync_d;

   pred_rec_t       fifo_head, head, push_rec;
   logic [CW-1:0]   fifo_count;
   logic            fifo_full, fifo_empty;
   logic            run, resolve, pc_miss, mispredict, do_push, do_pop;

   assign fifo_empty = (fifo_count == '0);

   // An empty queue resolves against a not-taken record at the resolving PC.
   always_comb begin
      head = fifo_head;
      if (fifo_empty) begin
         head.pc          = ex_pc;
         head.pred_taken  = 1'b0;
         head.pred_target = '0;
      end
   end

   assign run        = (state_q == RUN);
   assign resolve    = ex_valid && run;
   assign pc_miss    = (head.pc != ex_pc);
   assign mispredict = resolve && ((head.pred_taken != ex_taken) ||
                                   (ex_taken && (head.pred_target != ex_target)) ||
                                   pc_miss);
   assign do_pop     = resolve && !fifo_empty;
   // When full, a push fits only into the slot freed by a correct same-cycle pop.
   assign do_push    = if_push && run && !mispredict && (!fifo_full || resolve);

   assign push_rec.pc          = if_pc;
   assign push_rec.pred_taken  = if_pred_taken;
   assign push_rec.pred_target = if_pred_target;

   pred_fifo #(
      .DEPTH (PRED_DEPTH)
   ) u_pred_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (do_push),
      .pop_i   (do_pop),
      .clear_i (mispredict),
      .wdat_i  (push_rec),
      .rdat_o  (fifo_head),
      .count_o (fifo_count),
      .full_o  (fifo_full)
   );

   always_comb begin
      state_d    = state_q;
      redirect_d = redirect_q;
      desync_d   = desync_q | (resolve && (fifo_empty || pc_miss));
      case (state_q)
         RUN: begin
            if (mispredict) begin
               state_d    = FLUSH;
               redirect_d = ex_taken ? ex_target : ex_pc + XLEN'(INSTR_BYTES);
            end
         end
         FLUSH:   state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= RUN;
         redirect_q <= '0;
         desync_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         redirect_q <= redirect_d;
         desync_q   <= desync_d;
      end
   end

   assign q_full          = fifo_full;
   assign bp_update       = resolve;
   assign bp_actual_taken = ex_taken;
   assign flush           = (state_q == FLUSH);
   assign redirect_pc     = redirect_q;
   assign desync          = desync_q;

`ifdef BRU_PERF_CNT_EN
   logic [31:0] perf_br_q, perf_mis_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_br_q  <= '0;
         perf_mis_q <= '0;
      end else begin
         if (resolve)    perf_br_q  <= perf_br_q + 32'd1;
         if (mispredict) perf_mis_q <= perf_mis_q + 32'd1;
      end
   end

   assign perf_branches    = perf_br_q;
   assign perf_mispredicts = perf_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed test-plan scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_branch_resolve_unit;
   import bru_pkg::*;

   localparam int D = 4;

   logic        clk, reset_n;
   logic        if_push, if_pred_taken, ex_valid, ex_taken;
   logic [31:0] if_pc, if_pred_target, ex_pc, ex_target;
   logic        q_full, bp_update, bp_actual_taken, flush, desync;
   logic [31:0] redirect_pc;
`ifdef BRU_PERF_CNT_EN
   logic [31:0] perf_branches, perf_mispredicts;
`endif

   branch_resolve_unit #(.PRED_DEPTH(D), .XLEN(32)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .if_push         (if_push),
      .if_pc           (if_pc),
      .if_pred_taken   (if_pred_taken),
      .if_pred_target  (if_pred_target),
      .q_full          (q_full),
      .ex_valid        (ex_valid),
      .ex_pc           (ex_pc),
      .ex_taken        (ex_taken),
      .ex_target       (ex_target),
      .bp_update       (bp_update),
      .bp_actual_taken (bp_actual_taken),
      .flush           (flush),
      .redirect_pc     (redirect_pc),
`ifdef BRU_PERF_CNT_EN
      .perf_branches   (perf_branches),
      .perf_mispredicts(perf_mispredicts),
`endif
      .desync          (desync)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        t;
      logic [31:0] tg;
   } m_rec_t;

   m_rec_t      mq[$];
   bit          m_flush;
   bit          m_desync;
   logic [31:0] m_redir;
   int          m_br, m_mis;
   int          checks, errors;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_flush  = 0;
      m_desync = 0;
      m_redir  = '0;
      m_br     = 0;
      m_mis    = 0;
   endtask

   // One clock: drive at posedge+1, check at negedge, advance the model at the posedge.
   task automatic cyc(input bit p, input logic [31:0] ppc, input bit pt, input logic [31:0] ptg,
                      input bit ev, input logic [31:0] epc, input bit et, input logic [31:0] etg);
      bit     mis;
      int     sz;
      m_rec_t h;
      if_push = p; if_pc = ppc; if_pred_taken = pt; if_pred_target = ptg;
      ex_valid = ev; ex_pc = epc; ex_taken = et; ex_target = etg;
      @(negedge clk);
      chk("q_full", 64'(q_full), 64'(mq.size() == D));
      chk("flush", 64'(flush), 64'(m_flush));
      if (m_flush) chk("redirect_pc", 64'(redirect_pc), 64'(m_redir));
      chk("desync", 64'(desync), 64'(m_desync));
      chk("bp_update", 64'(bp_update), 64'(ev && !m_flush));
      if (ev && !m_flush) chk("bp_actual_taken", 64'(bp_actual_taken), 64'(et));
`ifdef BRU_PERF_CNT_EN
      chk("perf_branches", 64'(perf_branches), 64'(m_br));
      chk("perf_mispredicts", 64'(perf_mispredicts), 64'(m_mis));
`endif
      mis = 0;
      sz  = mq.size();
      if (m_flush) begin
         m_flush = 0;
      end else begin
         if (ev) begin
            if (sz == 0) h = '{epc, 1'b0, 32'h0};
            else         h = mq[0];
            mis = (h.t != et) || (et && h.tg != etg) || (h.pc != epc);
            if (sz == 0 || h.pc != epc) m_desync = 1;
            if (sz > 0) void'(mq.pop_front());
            m_br++;
            if (mis) begin
               m_mis++;
               mq.delete();
               m_flush = 1;
               m_redir = et ? etg : epc + 32'd4;
            end
         end
         if (p && !mis && (sz < D || ev)) mq.push_back('{ppc, pt, ptg});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic push(input logic [31:0] pc, input bit t, input logic [31:0] tg);
      cyc(1, pc, t, tg, 0, 0, 0, 0);
   endtask

   task automatic resolve(input logic [31:0] pc, input bit t, input logic [31:0] tg);
      cyc(0, 0, 0, 0, 1, pc, t, tg);
   endtask

   initial begin
      logic [31:0] next_pc;
      checks = 0;
      errors = 0;
      model_reset();
      reset_n = 0;
      if_push = 0; if_pc = 0; if_pred_taken = 0; if_pred_target = 0;
      ex_valid = 0; ex_pc = 0; ex_taken = 0; ex_target = 0;
      #2;
      chk("rst_flush", 64'(flush), 0);
      chk("rst_desync", 64'(desync), 0);
      chk("rst_q_full", 64'(q_full), 0);
      chk("rst_redirect_pc", 64'(redirect_pc), 0);
      @(posedge clk);
      #1 reset_n = 1;
      idle();

      // Correct taken prediction
      push(32'h100, 1, 32'h200);
      resolve(32'h100, 1, 32'h200);
      idle();
      // Direction mispredict
      push(32'h104, 1, 32'h200);
      resolve(32'h104, 0, 32'h0);
      idle();
      idle();
      // Target mispredict with younger entries, push during FLUSH dropped
      push(32'h10, 1, 32'h280);
      push(32'h14, 0, 32'h0);
      push(32'h18, 1, 32'h500);
      resolve(32'h10, 1, 32'h300);
      cyc(1, 32'h20, 1, 32'h600, 1, 32'h14, 0, 0);
      idle();
      resolve(32'h20, 0, 32'h0);
      idle();
      idle();
      // Full boundary and wrap, two rounds
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < D; i++) push(32'h1000 + 32'(r * 64 + i * 4), 0, 0);
         push(32'h1F00, 0, 0);
         cyc(1, 32'h2000 + 32'(r * 64), 1, 32'h2400, 1, 32'h1000 + 32'(r * 64), 0, 0);
         for (int i = 1; i < D; i++) resolve(32'h1000 + 32'(r * 64 + i * 4), 0, 0);
         resolve(32'h2000 + 32'(r * 64), 1, 32'h2400);
         idle();
      end
      // Empty-queue resolve: desync and redirect
      resolve(32'h50, 1, 32'h400);
      idle();
      idle();

      // Random traffic
      next_pc = 32'h8000;
      for (int n = 0; n < 400; n++) begin
         bit          p, pt, ev, et;
         logic [31:0] ptg, epc, etg;
         p   = ($urandom % 2) == 0;
         pt  = $urandom % 2;
         ptg = ($urandom % 2) ? 32'h200 : 32'h300;
         ev  = ($urandom % 2) == 0;
         if (mq.size() > 0 && ($urandom % 16) != 0) epc = mq[0].pc;
         else                                      epc = $urandom;
         if (mq.size() > 0 && ($urandom % 4) != 0) begin
            et  = mq[0].t;
            etg = mq[0].tg;
         end else begin
            et  = $urandom % 2;
            etg = ($urandom % 2) ? 32'h200 : 32'h300;
         end
         cyc(p, next_pc, pt, ptg, ev, epc, et, etg);
         if (p) next_pc = next_pc + 32'd4;
      end
      idle();
      idle();

      // Asynchronous reset mid-operation with three records queued
      push(32'h60, 0, 0);
      push(32'h64, 0, 0);
      push(32'h68, 0, 0);
      reset_n = 0;
      #1;
      chk("midrst_flush", 64'(flush), 0);
      chk("midrst_desync", 64'(desync), 0);
      chk("midrst_q_full", 64'(q_full), 0);
      model_reset();
      @(posedge clk);
      #1 reset_n = 1;
      idle();
      push(32'h70, 0, 0);
      resolve(32'h70, 0, 0);
      resolve(32'h74, 0, 0);
      idle();
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
EXE-stage branch resolution block, directly downstream of the gshare direction predictor and the fetch stage.
- Holds an in-order queue of fetch-time prediction records, one per predicted branch.
- Pops the head record when a branch resolves in EXE and compares it with the actual outcome.
- Drives the predictor's update/actual_taken inputs.
- On mispredict, issues a one-cycle pipeline flush and a redirect PC to fetch.

Parameters:
- PRED_DEPTH, 4, number of in-flight prediction records; power of 2, minimum 2.
- XLEN, 32, address width.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- if_push  input  1  fetch presents a branch prediction record this cycle
- if_pc  input  XLEN  PC of the predicted branch
- if_pred_taken  input  1  predictor output (prediction) captured at fetch
- if_pred_target  input  XLEN  predicted target; ignored if not taken
- q_full  output  1  queue cannot accept a push; fetch must stall
- ex_valid  input  1  a branch resolves in EXE this cycle
- ex_pc  input  XLEN  PC of the resolving branch
- ex_taken  input  1  actual direction
- ex_target  input  XLEN  actual taken target
- bp_update  output  1  to predictor update
- bp_actual_taken  output  1  to predictor actual_taken
- flush  output  1  kill IF/ID/EXE younger instructions
- redirect_pc  output  XLEN  fetch restart address, valid while flush=1
- desync  output  1  sticky: ex_valid seen with empty queue or PC mismatch

Behaviour:
Reset (asynchronous):
- Queue empty; rd_ptr, wr_ptr and count = 0.
- State = RUN.
- Outputs: flush=0, redirect_pc=0, desync=0, q_full=0.

Queue:
- Circular buffer with log2(PRED_DEPTH)-bit pointers that wrap modulo PRED_DEPTH.
- count is log2(PRED_DEPTH)+1 bits wide.
- q_full = (count==PRED_DEPTH), combinational.

Push:
- Accepted when if_push=1, state==RUN, and any of:
  - !q_full;
  - q_full with a same-cycle pop that does not mispredict.
- Otherwise the push is dropped. Fetch must hold the record while q_full is asserted.

Pop/compare (ex_valid=1):
- Head record {pc, pred_taken, pred_target} is popped.
- Mispredict = (pred_taken != ex_taken) OR (ex_taken AND pred_target != ex_target) OR (pc != ex_pc).
- Empty queue with ex_valid: treat the head as {ex_pc, 0, 0}.
- Empty queue or PC mismatch also sets desync=1. desync is cleared only by reset.

Predictor update:
- bp_update = ex_valid and bp_actual_taken = ex_taken, combinational, same cycle.
- The predictor registers its index internally, so no extra delay is added here.

FSM:
- RUN: normal operation. On ex_valid with mispredict:
  - next state = FLUSH;
  - registered redirect_pc <= ex_taken ? ex_target : ex_pc+4 (mod 2^XLEN);
  - at that edge the whole queue is cleared (pointers and count = 0), because all younger records are wrong-path.
- FLUSH: flush=1 for exactly one cycle, then return to RUN.
  - Pushes and ex_valid in FLUSH are ignored (wrong-path).
  - bp_update is still forced to 0 in FLUSH.
- A correct prediction never leaves RUN. Back-to-back resolves at one per cycle are supported.
- Simultaneous push and mispredicting pop: the push is dropped (it is younger, wrong-path).
- flush is registered: asserted exactly 1 cycle after the mispredicting ex_valid.

Optional Feature:
Macro BRU_PERF_CNT_EN.
- Defined:
  - adds outputs perf_branches[31:0] and perf_mispredicts[31:0];
  - perf_branches increments on each counted ex_valid (RUN only);
  - perf_mispredicts increments on each mispredict;
  - both reset to 0, wrap at 2^32, and are readable every cycle.
- Not defined: the ports and counters do not exist. Core behaviour is identical either way.

Decomposition:
- Package bru_pkg:
  - typedef pred_rec_t {pc, pred_taken, pred_target};
  - enum bru_state_e {RUN, FLUSH};
  - localparam INSTR_BYTES=4.
- One natural sub-module: pred_fifo (parameterised circular buffer with push/pop/clear, count, full/empty).
- Compare logic and FSM stay in the top level.

Test Plan:
1. Reset mid-operation: 3 records queued, assert reset_n=0 for 1 cycle -> count=0, flush=0, desync=0, q_full=0 immediately (asynchronous).
2. Correct prediction: push {0x100, taken, 0x200}, resolve ex_pc=0x100, taken, target 0x200 -> bp_update=1 and bp_actual_taken=1 that cycle; flush never asserted; queue empty.
3. Direction mispredict: push {0x104, taken=1}, resolve not-taken -> next cycle flush=1 with redirect_pc=0x108; the following cycle flush=0; queue empty.
4. Target mispredict plus younger entries: push 3 records, the head resolves taken to 0x300 vs predicted 0x280 -> redirect_pc=0x300; queue cleared; a push in the FLUSH cycle is dropped.
5. Full boundary: PRED_DEPTH=4, push 4 records -> q_full=1. A 5th push alone is dropped. A 5th push with a same-cycle correct pop is accepted, count stays 4, and pointers wrap correctly.
6. Desync: ex_valid with empty queue, ex_taken=1, ex_target=0x400 -> treated as mispredict, redirect_pc=0x400, desync=1 sticky. With BRU_PERF_CNT_EN defined, perf_mispredicts=1.
